// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master: FSM state encoding and
// the per-transfer mode captured at accept.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } mode_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: counts 0..CLK_DIV-1 while enabled and
// flags the terminal count. The counter is held at 0 while disabled.
module spi_clk_div #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/spi_master_cfg.sv
// Single-word SPI master with per-transfer cpol/cpha/bit order and chip select.
// Receive path is built only when SPI_MASTER_RX_EN is defined; otherwise rx_data is 0.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 10,
    parameter int NUM_CS  = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      tx_valid,
    output logic                                      tx_ready,
    input  logic [DATA_W-1:0]                         tx_data,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
    input  logic                                      cpol,
    input  logic                                      cpha,
    input  logic                                      lsb_first,
    output logic                                      sclk,
    output logic                                      mosi,
    output logic [NUM_CS-1:0]                         cs_n,
    input  logic                                      miso,
    output logic                                      rx_valid,
    output logic [DATA_W-1:0]                         rx_data,
    output logic                                      busy
);

    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    state_t            state;
    state_t            state_next;
    mode_t             mode_q;
    logic [CS_W-1:0]   cs_sel_q;
    logic [DATA_W-1:0] tx_sh;
    logic [EDGE_W-1:0] edge_cnt;
    logic              sclk_q;
    logic              rx_valid_q;
    logic              ready_q;
    logic              tick;
    logic              accept;
    logic              odd_edge;
    logic              last_edge;
    logic              do_shift;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != IDLE),
        .tick  (tick)
    );

    // ready_q keeps tx_ready low during reset and for the release cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign accept    = (state == IDLE) && tx_valid && ready_q;
    // edge_cnt holds edges already made, so the edge a tick produces is edge_cnt+1.
    assign odd_edge  = ~edge_cnt[0];
    assign last_edge = (edge_cnt == EDGE_W'(2 * DATA_W - 1));
    // With cpha=1 the first bit is already on mosi from accept, so edge 1 presents nothing new.
    assign do_shift  = mode_q.cpha ? (odd_edge && (edge_cnt != '0))
                                   : (!odd_edge && !last_edge);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)            state_next = LEAD;
            LEAD:    if (tick)              state_next = XFER;
            XFER:    if (tick && last_edge) state_next = TRAIL;
            TRAIL:   if (tick)              state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= '0;
            cs_sel_q   <= '0;
            tx_sh      <= '0;
            edge_cnt   <= '0;
            sclk_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (accept) begin
                mode_q   <= {cpol, cpha, lsb_first};
                cs_sel_q <= cs_sel;
                tx_sh    <= tx_data;
                edge_cnt <= '0;
                sclk_q   <= cpol;
            end else if (state == XFER && tick) begin
                sclk_q   <= ~sclk_q;
                edge_cnt <= edge_cnt + 1'b1;
                if (do_shift) begin
                    tx_sh <= mode_q.lsb_first ? (tx_sh >> 1) : (tx_sh << 1);
                end
            end else if (state == TRAIL && tick) begin
                rx_valid_q <= 1'b1;
            end
        end
    end

`ifdef SPI_MASTER_RX_EN
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] rx_data_q;
    logic              do_sample;

    assign do_sample = mode_q.cpha ? !odd_edge : odd_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh     <= '0;
            rx_data_q <= '0;
        end else begin
            if (accept) begin
                rx_sh <= '0;
            end else if (state == XFER && tick && do_sample) begin
                rx_sh <= mode_q.lsb_first ? {miso, rx_sh[DATA_W-1:1]}
                                          : {rx_sh[DATA_W-2:0], miso};
            end
            if (state == TRAIL && tick) begin
                rx_data_q <= rx_sh;
            end
        end
    end

    assign rx_data = rx_data_q;
`else
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_data     = '0;
`endif

    always_comb begin
        cs_n = '1;
        if (state != IDLE) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (cs_sel_q == CS_W'(i)) cs_n[i] = 1'b0;
            end
        end
    end

    assign sclk     = (state == IDLE) ? (ready_q & cpol) : sclk_q;
    assign mosi     = (state == IDLE) ? 1'b0
                    : (mode_q.lsb_first ? tx_sh[0] : tx_sh[DATA_W-1]);
    assign tx_ready = (state == IDLE) && ready_q;
    assign busy     = (state != IDLE);
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg (12-bit, CLK_DIV=10); a 3-CS twin covers an out-of-range cs_sel.
module tb_spi_master_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_valid = 1'b0;
    logic [11:0] tx_data = '0;
    logic [1:0]  sel_drv = '0;
    logic        cpol = 1'b1;
    logic        cpha = 1'b0;
    logic        lsb_first = 1'b0;
    logic        loopback = 1'b0;
    logic        miso_drv = 1'b0;
    logic        miso;

    logic        tx_ready, sclk, mosi, rx_valid, busy;
    logic [1:0]  cs_n;
    logic [11:0] rx_data;
    logic        tx_ready3, sclk3, mosi3, rx_valid3, busy3;
    logic [2:0]  cs_n3;
    logic [11:0] rx_data3;

    int checks = 0;
    int failures = 0;

    assign miso = loopback ? mosi : miso_drv;

    always #5 clk = ~clk;

    spi_master_cfg #(.DATA_W(12), .CLK_DIV(10), .NUM_CS(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .cs_sel(sel_drv[0]), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy)
    );

    spi_master_cfg #(.DATA_W(12), .CLK_DIV(10), .NUM_CS(3)) u_dut_cs3 (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready3),
        .tx_data(tx_data), .cs_sel(sel_drv), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .sclk(sclk3), .mosi(mosi3), .cs_n(cs_n3),
        .miso(miso), .rx_valid(rx_valid3), .rx_data(rx_data3), .busy(busy3)
    );

    // Observations collected by watch_xfer for the test tasks to judge.
    logic [11:0] cur_slave;
    logic        cur_pha, cur_lsb;
    int          mon_cycles, mon_toggles, mon_samples;
    logic [11:0] mon_slave_rx;
    logic [1:0]  mon_cs;
    logic [2:0]  mon_cs3;
    bit          mon_cs3_low, mon_twin_done, mon_timeout, mon_ready_busy;
    logic        mon_idle_sclk, mon_end_sclk;

    function automatic logic [11:0] exp_rx(input logic [11:0] w);
`ifdef SPI_MASTER_RX_EN
        return w;
`else
        return 12'h000;
`endif
    endfunction

    function automatic logic slave_bit(input logic [11:0] w, input logic lsb, input int idx);
        int i;
        i = (idx > 11) ? 11 : idx;
        return lsb ? w[i] : w[11-i];
    endfunction

    task automatic start_xfer(input logic [11:0] data, input logic [1:0] sel, input logic pol,
                              input logic pha, input logic lsb, input logic [11:0] slave_word);
        @(negedge clk);
        tx_data = data; sel_drv = sel; cpol = pol; cpha = pha; lsb_first = lsb;
        cur_slave = slave_word; cur_pha = pha; cur_lsb = lsb;
        miso_drv = slave_bit(slave_word, lsb, 0);
        #1 mon_idle_sclk = sclk;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    // Runs the slave model from the accept edge until rx_valid (bounded).
    task automatic watch_xfer();
        logic prev;
        bit   done;
        mon_cycles = 0; mon_toggles = 0; mon_samples = 0; mon_slave_rx = '0;
        mon_cs = '0; mon_cs3 = '0; mon_cs3_low = 0; mon_twin_done = 0;
        mon_timeout = 0; mon_ready_busy = 0; done = 0;
        prev = sclk;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            mon_cycles++;
            if (sclk !== prev) begin
                mon_toggles++;
                prev = sclk;
                if ((!cur_pha && (mon_toggles % 2 == 1)) || (cur_pha && (mon_toggles % 2 == 0))) begin
                    if (mon_samples < 12) mon_slave_rx[cur_lsb ? mon_samples : 11 - mon_samples] = mosi;
                    mon_samples++;
                end
                miso_drv = slave_bit(cur_slave, cur_lsb, cur_pha ? (mon_toggles - 1) / 2 : mon_toggles / 2);
            end
            if (mon_cycles == 5) begin
                mon_cs = cs_n;
                mon_cs3 = cs_n3;
            end
            if (cs_n3 !== 3'b111) mon_cs3_low = 1;
            if (tx_ready && busy) mon_ready_busy = 1;
            if (rx_valid3) mon_twin_done = 1;
            if (rx_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) mon_timeout = 1;
        mon_end_sclk = sclk;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL rst_cs_n got=%b exp=11", cs_n); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", sclk); end
        checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", mosi); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL rst_tx_ready got=%b exp=0", tx_ready); end
        checks++; if ({rx_valid, busy} !== 2'b00) begin failures++; $display("FAIL rst_valid_busy got=%b exp=00", {rx_valid, busy}); end
        checks++; if (rx_data !== 12'h000) begin failures++; $display("FAIL rst_rx_data got=%h exp=000", rx_data); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", tx_ready); end
        checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL idle_sclk_cpol1 got=%b exp=1", sclk); end
    endtask

    task automatic test_loopback();
        logic [11:0] held;
        loopback = 1'b1;
        start_xfer(12'hA5C, 2'd0, 1'b0, 1'b0, 1'b1, 12'h000);
        watch_xfer();
        checks++; if (mon_timeout || mon_cycles != 260) begin failures++; $display("FAIL lb_latency got=%0d exp=260", mon_cycles); end
        checks++; if (rx_data !== exp_rx(12'hA5C)) begin failures++; $display("FAIL lb_rx_data got=%h exp=%h", rx_data, exp_rx(12'hA5C)); end
        checks++; if (mon_slave_rx !== 12'hA5C) begin failures++; $display("FAIL lb_mosi_word got=%h exp=a5c", mon_slave_rx); end
        checks++; if (mon_cs !== 2'b10) begin failures++; $display("FAIL lb_cs_n got=%b exp=10", mon_cs); end
        checks++; if (mon_ready_busy) begin failures++; $display("FAIL lb_ready_while_busy got=1 exp=0"); end
        held = rx_data;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (rx_valid !== 1'b0 || rx_data !== exp_rx(12'hA5C)) begin
            failures++; $display("FAIL lb_hold got=%b/%h exp=0/%h", rx_valid, rx_data, exp_rx(12'hA5C));
        end
        checks++; if (cs_n !== 2'b11 || mosi !== 1'b0) begin failures++; $display("FAIL lb_idle_out got=%b/%b exp=11/0", cs_n, mosi); end
        loopback = 1'b0;
        if (held !== rx_data) begin end
    endtask

    task automatic test_modes();
        logic pol, pha;
        for (int m = 0; m < 4; m++) begin
            pol = m[1];
            pha = m[0];
            start_xfer(12'h3F0, 2'd0, pol, pha, 1'b0, 12'h0F3);
            watch_xfer();
            checks++; if (mon_idle_sclk !== pol) begin failures++; $display("FAIL mode%0d_idle_sclk got=%b exp=%b", m, mon_idle_sclk, pol); end
            checks++; if (mon_end_sclk !== pol) begin failures++; $display("FAIL mode%0d_end_sclk got=%b exp=%b", m, mon_end_sclk, pol); end
            checks++; if (mon_toggles != 24 || mon_samples != 12) begin
                failures++; $display("FAIL mode%0d_edges got=%0d/%0d exp=24/12", m, mon_toggles, mon_samples);
            end
            checks++; if (rx_data !== exp_rx(12'h0F3)) begin failures++; $display("FAIL mode%0d_rx got=%h exp=%h", m, rx_data, exp_rx(12'h0F3)); end
            checks++; if (mon_slave_rx !== 12'h3F0) begin failures++; $display("FAIL mode%0d_mosi got=%h exp=3f0", m, mon_slave_rx); end
            checks++; if (mon_timeout || mon_cycles != 260) begin failures++; $display("FAIL mode%0d_latency got=%0d exp=260", m, mon_cycles); end
        end
    endtask

    task automatic test_cs_sel();
        start_xfer(12'h00F, 2'd1, 1'b0, 1'b0, 1'b0, 12'h0C3);
        watch_xfer();
        checks++; if (mon_cs !== 2'b01) begin failures++; $display("FAIL cs1_cs_n got=%b exp=01", mon_cs); end
        checks++; if (mon_cs3 !== 3'b101) begin failures++; $display("FAIL cs1_twin_cs_n got=%b exp=101", mon_cs3); end
        start_xfer(12'h0F0, 2'd3, 1'b0, 1'b0, 1'b0, 12'h3C5);
        watch_xfer();
        checks++; if (mon_cs3_low) begin failures++; $display("FAIL cs3_never_low got=%b exp=111 throughout", mon_cs3); end
        checks++; if (!mon_twin_done || mon_timeout) begin failures++; $display("FAIL cs3_completes got=%0d exp=1", mon_twin_done); end
        checks++; if (rx_data3 !== exp_rx(12'h3C5)) begin failures++; $display("FAIL cs3_rx got=%h exp=%h", rx_data3, exp_rx(12'h3C5)); end
    endtask

    task automatic test_reset_mid();
        logic prev;
        int   tg;
        bit   seen_rx;
        loopback = 1'b1;
        start_xfer(12'hFFF, 2'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        prev = sclk; tg = 0; seen_rx = 0;
        for (int c = 0; c < 400 && tg < 7; c++) begin
            @(posedge clk); #1;
            if (sclk !== prev) begin tg++; prev = sclk; end
            if (rx_valid) seen_rx = 1;
        end
        checks++; if (tg != 7) begin failures++; $display("FAIL rmid_reach_edge7 got=%0d exp=7", tg); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, tx_ready, rx_valid, sclk, mosi} !== 5'b00000 || cs_n !== 2'b11) begin
            failures++; $display("FAIL rmid_reset_out got=%b cs=%b exp=00000 cs=11", {busy, tx_ready, rx_valid, sclk, mosi}, cs_n);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (rx_valid) seen_rx = 1;
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready_after got=%b exp=1", tx_ready); end
        repeat (20) begin
            @(posedge clk); #1;
            if (rx_valid || busy) seen_rx = 1;
        end
        checks++; if (seen_rx) begin failures++; $display("FAIL rmid_no_rx_valid got=1 exp=0"); end
        start_xfer(12'h123, 2'd0, 1'b0, 1'b0, 1'b0, 12'h000);
        watch_xfer();
        checks++; if (mon_timeout || mon_cycles != 260) begin failures++; $display("FAIL rmid_next_latency got=%0d exp=260", mon_cycles); end
        checks++; if (rx_data !== exp_rx(12'h123) || mon_slave_rx !== 12'h123) begin
            failures++; $display("FAIL rmid_next_word got=%h/%h exp=%h/123", rx_data, mon_slave_rx, exp_rx(12'h123));
        end
        loopback = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          c1, c2, idle_seen, extra_busy;
        logic [11:0] rx1;
        bit          ok1, ok2;
        loopback = 1'b1;
        @(negedge clk);
        tx_data = 12'h5A3; sel_drv = 2'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        c1 = 0; ok1 = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            tx_data = tx_data + 12'h111;
            @(posedge clk); #1;
            c1++;
            if (rx_valid) begin ok1 = 1; break; end
        end
        rx1 = rx_data;
        idle_seen = busy ? 0 : 1;
        @(negedge clk);
        tx_data = 12'hC3A;
        c2 = 0; ok2 = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            c2++;
            if (rx_valid) begin ok2 = 1; break; end
            @(negedge clk);
            tx_data = ~tx_data;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        extra_busy = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (busy) extra_busy++;
        end
        checks++; if (!ok1 || c1 != 260) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=260", c1); end
        checks++; if (rx1 !== exp_rx(12'h5A3)) begin failures++; $display("FAIL b2b_first_word got=%h exp=%h", rx1, exp_rx(12'h5A3)); end
        checks++; if (idle_seen != 1 || !ok2 || c2 != 261) begin
            failures++; $display("FAIL b2b_gap got=%0d idle=%0d exp=261 idle=1", c2, idle_seen);
        end
        checks++; if (rx_data !== exp_rx(12'hC3A)) begin failures++; $display("FAIL b2b_second_word got=%h exp=%h", rx_data, exp_rx(12'hC3A)); end
        checks++; if (extra_busy != 0) begin failures++; $display("FAIL b2b_sent_once got=%0d exp=0", extra_busy); end
        loopback = 1'b0;
    endtask

    task automatic test_miso_high();
        start_xfer(12'h555, 2'd0, 1'b0, 1'b1, 1'b1, 12'hFFF);
        watch_xfer();
        checks++; if (rx_data !== exp_rx(12'hFFF)) begin failures++; $display("FAIL miso1_rx got=%h exp=%h", rx_data, exp_rx(12'hFFF)); end
        checks++; if (mon_timeout || mon_cycles != 260) begin failures++; $display("FAIL miso1_latency got=%0d exp=260", mon_cycles); end
        checks++; if (mon_slave_rx !== 12'h555) begin failures++; $display("FAIL miso1_mosi got=%h exp=555", mon_slave_rx); end
    endtask

    initial begin
        test_reset();
        cpol = 1'b0;
        test_loopback();
        test_modes();
        test_cs_sel();
        test_reset_mid();
        test_back_to_back();
        test_miso_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
